// File: rtl/mdu_div_seq.sv
// Multi-cycle RV64M divide/remainder sequencer: radix-2 restoring divider, one quotient bit
// per cycle, with divide-by-zero and signed-overflow results resolved at accept.
module mdu_div_seq #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic            req_word,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    output logic            stall,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_result
);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e          state_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN-1:0] result_q;
    logic [6:0]      cnt_q;
    logic            word_q;
    logic            sel_rem_q;
    logic            neg_quo_q;
    logic            neg_rem_q;
    logic            valid_q;

    // Every request on this port is a divide op, so funct3[2] carries no information.
    logic unused_funct3;
    assign unused_funct3 = req_funct3[2];

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    // ---------------------------------------------------------------- operand prep at accept
    logic            op_signed;
    logic [XLEN-1:0] a_eff;
    logic [XLEN-1:0] b_eff;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] min_eff;
    logic            div_zero;
    logic            overflow;
    logic            special;
    logic [XLEN-1:0] spec_quo;
    logic [XLEN-1:0] spec_rem;
    logic [XLEN-1:0] spec_sel;
    logic [XLEN-1:0] spec_result;
    logic            accept;

    always_comb begin
        op_signed = ~req_funct3[0];
        if (req_word) begin
            a_eff   = op_signed ? sext32(req_rs1[31:0]) : {{(XLEN-32){1'b0}}, req_rs1[31:0]};
            b_eff   = op_signed ? sext32(req_rs2[31:0]) : {{(XLEN-32){1'b0}}, req_rs2[31:0]};
            min_eff = {{(XLEN-31){1'b1}}, 31'b0};
        end else begin
            a_eff   = req_rs1;
            b_eff   = req_rs2;
            min_eff = {1'b1, {(XLEN-1){1'b0}}};
        end
        a_mag    = (op_signed && a_eff[XLEN-1]) ? -a_eff : a_eff;
        b_mag    = (op_signed && b_eff[XLEN-1]) ? -b_eff : b_eff;
        div_zero = (b_eff == '0);
        overflow = op_signed && (a_eff == min_eff) && (b_eff == '1);
        special  = div_zero || overflow;
        spec_quo = div_zero ? '1 : a_eff;
        spec_rem = div_zero ? a_eff : '0;
        spec_sel = req_funct3[1] ? spec_rem : spec_quo;
        spec_result = req_word ? sext32(spec_sel[31:0]) : spec_sel;
    end

    assign req_ready = (state_q == StIdle) && !flush;
    assign accept    = req_valid && req_ready;

    // ---------------------------------------------------------------- one restoring step
    logic [XLEN:0]   shifted;
    logic            trial_ge;
    logic [XLEN-1:0] rem_nx;
    logic [XLEN-1:0] quo_nx;
    logic [XLEN-1:0] quo_fin;
    logic [XLEN-1:0] rem_fin;
    logic [XLEN-1:0] sel_fin;
    logic [XLEN-1:0] calc_result;

    always_comb begin
        shifted  = {rem_q, quo_q[XLEN-1]};
        trial_ge = (shifted >= {1'b0, dvs_q});
        // When the trial succeeds the true difference is below the divisor, so it fits XLEN bits.
        rem_nx   = trial_ge ? (shifted[XLEN-1:0] - dvs_q) : shifted[XLEN-1:0];
        quo_nx   = {quo_q[XLEN-2:0], trial_ge};
        quo_fin  = neg_quo_q ? -quo_nx : quo_nx;
        rem_fin  = neg_rem_q ? -rem_nx : rem_nx;
        sel_fin  = sel_rem_q ? rem_fin : quo_fin;
        calc_result = word_q ? sext32(sel_fin[31:0]) : sel_fin;
    end

    // ---------------------------------------------------------------- sequencer
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= StIdle;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            word_q    <= 1'b0;
            sel_rem_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            valid_q   <= 1'b0;
        end else if (flush) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    valid_q <= 1'b0;
                    if (accept) begin
                        word_q    <= req_word;
                        sel_rem_q <= req_funct3[1];
                        neg_quo_q <= op_signed && (a_eff[XLEN-1] ^ b_eff[XLEN-1]);
                        neg_rem_q <= op_signed && a_eff[XLEN-1];
                        if (special) begin
                            result_q <= spec_result;
                            valid_q  <= 1'b1;
                            state_q  <= StDone;
                        end else begin
                            // Word dividends are pre-aligned so their MSB enters first.
                            quo_q   <= req_word ? {a_mag[31:0], 32'b0} : a_mag;
                            rem_q   <= '0;
                            dvs_q   <= b_mag;
                            cnt_q   <= req_word ? 7'd32 : 7'd64;
                            state_q <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    quo_q <= quo_nx;
                    rem_q <= rem_nx;
                    cnt_q <= cnt_q - 7'd1;
                    if (cnt_q == 7'd1) begin
                        result_q <= calc_result;
                        valid_q  <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    valid_q <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign stall       = (state_q == StCalc) || ((state_q == StIdle) && req_valid && !flush);
    assign resp_valid  = valid_q;
    assign resp_result = result_q;

endmodule

// File: tb/tb_mdu_div_seq.sv
// Self-checking bench for mdu_div_seq: expected results and latencies are queued when an
// op is driven and compared when resp_valid pulses.
module tb_mdu_div_seq;

    logic        clk;
    logic        rstn;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic        req_word;
    logic [63:0] req_rs1;
    logic [63:0] req_rs2;
    logic        stall;
    logic        resp_valid;
    logic [63:0] resp_result;

    mdu_div_seq #(.XLEN(64)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_funct3 (req_funct3),
        .req_word   (req_word),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_result(resp_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] last_res = 64'd0;

    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;

    // Reference divide; latency counted in posedges from the accept edge inclusive.
    function automatic void model(input logic [2:0] f3, input logic w, input logic [63:0] a,
                                  input logic [63:0] b, output logic [63:0] res, output int lat);
        logic        sgn;
        logic [31:0] a32, b32, q32, r32, s32;
        logic [63:0] q64, r64;
        sgn = ~f3[0];
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 32'd0) begin
                q32 = 32'hFFFF_FFFF; r32 = a32; lat = 1;
            end else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32; r32 = 32'd0; lat = 1;
            end else begin
                if (sgn) begin
                    q32 = $signed(a32) / $signed(b32);
                    r32 = $signed(a32) % $signed(b32);
                end else begin
                    q32 = a32 / b32;
                    r32 = a32 % b32;
                end
                lat = 33;
            end
            s32 = f3[1] ? r32 : q32;
            res = {{32{s32[31]}}, s32};
        end else begin
            if (b == 64'd0) begin
                q64 = '1; r64 = a; lat = 1;
            end else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin
                q64 = a; r64 = 64'd0; lat = 1;
            end else begin
                if (sgn) begin
                    q64 = $signed(a) / $signed(b);
                    r64 = $signed(a) % $signed(b);
                end else begin
                    q64 = a / b;
                    r64 = a % b;
                end
                lat = 65;
            end
            res = f3[1] ? r64 : q64;
        end
    endfunction

    task automatic issue(input logic [2:0] f3, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input string name);
        exp_t e;
        int   edges;
        int   stalls;
        model(f3, w, a, b, e.res, e.lat);
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b1; req_funct3 = f3; req_word = w; req_rs1 = a; req_rs2 = b;
        #1;
        stalls = stall ? 1 : 0;
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s ready: got %b want 1", name, req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0; req_rs1 = '1; req_rs2 = '1;
        #1;
        edges = 1;
        while (resp_valid !== 1'b1 && edges < 200) begin
            if (stall === 1'b1) stalls++;
            @(negedge clk);
            edges++;
        end
        e = sb.pop_front();
        n_vec++;
        if (resp_valid !== 1'b1) begin
            n_err++;
            $display("FAIL %s timeout: no resp_valid within %0d cycles", name, edges);
            return;
        end
        n_vec += 4;
        if (resp_result !== e.res) begin
            n_err++;
            $display("FAIL %s result: got %h want %h", name, resp_result, e.res);
        end
        if (edges != e.lat) begin
            n_err++;
            $display("FAIL %s latency: got %0d want %0d", name, edges, e.lat);
        end
        if (stalls != e.lat) begin
            n_err++;
            $display("FAIL %s stall cycles: got %0d want %0d", name, stalls, e.lat);
        end
        if (stall !== 1'b0) begin
            n_err++;
            $display("FAIL %s stall in done: got %b want 0", name, stall);
        end
        last_res = e.res;
        @(negedge clk);
        n_vec += 2;
        if (resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s pulse: resp_valid got %b want 0", name, resp_valid);
        end
        if (resp_result !== e.res) begin
            n_err++;
            $display("FAIL %s hold: got %h want %h", name, resp_result, e.res);
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0; flush = 1'b0; req_valid = 1'b0;
        req_funct3 = F_DIV; req_word = 1'b0; req_rs1 = '0; req_rs2 = '0;
        repeat (3) @(negedge clk);
        #1;
        n_vec += 4;
        if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset resp_valid: got %b want 0", resp_valid); end
        if (resp_result !== 64'd0) begin n_err++; $display("FAIL reset resp_result: got %h want 0", resp_result); end
        if (stall !== 1'b0) begin n_err++; $display("FAIL reset stall: got %b want 0", stall); end
        if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset req_ready: got %b want 1", req_ready); end
        rstn = 1'b1;
        last_res = 64'd0;
    endtask

    task automatic test_unsigned;
        issue(F_DIVU, 1'b0, 64'd100, 64'd7, "divu_100_7");
        issue(F_REMU, 1'b0, 64'd100, 64'd7, "remu_100_7");
    endtask

    task automatic test_signed;
        issue(F_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, "div_m7_2");
        issue(F_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, "rem_m7_2");
        issue(F_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'd3, "div_min_3");
    endtask

    task automatic test_div_zero;
        issue(F_DIVU, 1'b0, 64'h1234, 64'd0, "divu_zero");
        issue(F_REMU, 1'b0, 64'h1234, 64'd0, "remu_zero");
        issue(F_REM, 1'b1, 64'h0000_0001_8000_0000, 64'd0, "remw_zero");
        issue(F_DIVU, 1'b1, 64'h5, 64'hFFFF_FFFF_0000_0000, "divuw_zero_low");
    endtask

    task automatic test_overflow;
        issue(F_DIV, 1'b0, 64'h8000_0000_0000_0000, '1, "div_ovf");
        issue(F_DIV, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, "divw_ovf");
        issue(F_REM, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, "remw_ovf");
    endtask

    task automatic test_word;
        issue(F_DIVU, 1'b1, 64'hABCD_0000_FFFF_FFFE, 64'h2, "divuw_big");
        issue(F_DIV, 1'b1, 64'h1234_5678_FFFF_FFF0, 64'h3, "divw_neg");
        issue(F_REMU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h10, "remuw");
    endtask

    task automatic test_random;
        logic [2:0]  f3;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        for (int i = 0; i < 12; i++) begin
            f3 = 3'b100 | 3'($urandom_range(0, 3));
            w  = 1'($urandom_range(0, 1));
            a  = {$urandom, $urandom};
            if (i % 3 == 0) b = 64'($urandom_range(1, 50));
            else if (i % 3 == 1) b = -64'($urandom_range(1, 50));
            else b = {$urandom, $urandom};
            issue(f3, w, a, b, "random");
        end
    endtask

    task automatic test_busy_ignored;
        exp_t e;
        int   edges;
        model(F_DIVU, 1'b0, 64'd100, 64'd7, e.res, e.lat);
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b1; req_funct3 = F_DIVU; req_word = 1'b0; req_rs1 = 64'd100; req_rs2 = 64'd7;
        @(negedge clk);
        req_rs1 = 64'd1000; req_rs2 = 64'd3; req_funct3 = F_REMU;
        #1;
        n_vec++;
        if (req_ready !== 1'b0) begin n_err++; $display("FAIL busy ready: got %b want 0", req_ready); end
        edges = 1;
        repeat (3) begin @(negedge clk); edges++; end
        req_valid = 1'b0;
        while (resp_valid !== 1'b1 && edges < 200) begin @(negedge clk); edges++; end
        e = sb.pop_front();
        n_vec += 2;
        if (resp_result !== e.res) begin
            n_err++; $display("FAIL busy result: got %h want %h", resp_result, e.res);
        end
        if (edges != e.lat) begin
            n_err++; $display("FAIL busy latency: got %0d want %0d", edges, e.lat);
        end
        if (resp_valid === 1'b1) last_res = e.res;
        @(negedge clk);
    endtask

    task automatic test_flush;
        int seen;
        @(negedge clk);
        req_valid = 1'b1; req_funct3 = F_DIVU; req_word = 1'b0; req_rs1 = 64'd100; req_rs2 = 64'd7;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        #1;
        n_vec++;
        if (req_ready !== 1'b0) begin n_err++; $display("FAIL flush ready: got %b want 0", req_ready); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        n_vec += 3;
        if (stall !== 1'b0) begin n_err++; $display("FAIL flush stall: got %b want 0", stall); end
        if (resp_valid !== 1'b0) begin n_err++; $display("FAIL flush resp_valid: got %b want 0", resp_valid); end
        if (resp_result !== last_res) begin
            n_err++; $display("FAIL flush result kept: got %h want %h", resp_result, last_res);
        end
        seen = 0;
        repeat (70) begin @(negedge clk); if (resp_valid === 1'b1) seen++; end
        n_vec++;
        if (seen != 0) begin n_err++; $display("FAIL flush late resp: got %0d pulses want 0", seen); end
        issue(F_DIVU, 1'b0, 64'd9, 64'd3, "divu_after_flush");
        // Flush in the same cycle as a request blocks the accept.
        @(negedge clk);
        req_valid = 1'b1; flush = 1'b1; req_funct3 = F_DIVU; req_rs1 = 64'd50; req_rs2 = 64'd5;
        #1;
        n_vec += 2;
        if (req_ready !== 1'b0) begin n_err++; $display("FAIL flushreq ready: got %b want 0", req_ready); end
        if (stall !== 1'b0) begin n_err++; $display("FAIL flushreq stall: got %b want 0", stall); end
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        #1;
        n_vec++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL flushreq accepted: stall got %b want 0", stall); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        req_valid = 1'b1; req_funct3 = F_DIVU; req_word = 1'b0; req_rs1 = 64'd100; req_rs2 = 64'd7;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (10) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        #1;
        n_vec += 3;
        if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rstmid resp_valid: got %b want 0", resp_valid); end
        if (resp_result !== 64'd0) begin n_err++; $display("FAIL rstmid result: got %h want 0", resp_result); end
        if (stall !== 1'b0) begin n_err++; $display("FAIL rstmid stall: got %b want 0", stall); end
        rstn = 1'b1;
        last_res = 64'd0;
        issue(F_DIV, 1'b0, 64'd42, -64'd5, "div_after_reset");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global timeout");
        $fatal(1, "simulation timeout");
    end

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_word();
        test_busy_ignored();
        test_flush();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
